dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//   Direct-mapped, write-back, write-allocate data cache between the single-cycle CPU's
//   load/store path and the byte-addressed data memory. Stalls the CPU via BUSYWAIT on miss.
//   Sequences the data memory block handshake: writes back a dirty victim, fetches the new block.
// PARAMETERS
//   ADDR_W      8   CPU byte-address width
//   INDEX_W     3   index bits (2**INDEX_W lines)
//   OFFSET_W    2   byte-offset bits (2**OFFSET_W bytes/block; block = 8*2**OFFSET_W bits)
//   TAG_W is ADDR_W-INDEX_W-OFFSET_W and is derived, never overridden.
// PORTS
//   CLK            in   1    clock, all state updates on posedge
//   RESET          in   1    synchronous, active-high
//   READ           in   1    CPU load request
//   WRITE          in   1    CPU store request
//   ADDRESS        in   ADDR_W  CPU byte address {tag,index,offset}
//   WRITEDATA      in   8    store byte
//   READDATA       out  8    load byte
//   BUSYWAIT       out  1    CPU stall; CPU holds request and PC while high
//   MEM_READ       out  1    block fetch request
//   MEM_WRITE      out  1    block write-back request
//   MEM_ADDRESS    out  ADDR_W-OFFSET_W  block address
//   MEM_WRITEDATA  out  8*2**OFFSET_W    victim block
//   MEM_READDATA   in   8*2**OFFSET_W    fetched block
//   MEM_BUSYWAIT   in   1    memory busy; asserted in the same cycle a request appears
// BEHAVIOUR
//   - Per line: valid, dirty, tag, data. hit = valid[idx] && tag[idx]==ADDRESS tag.
//   - States: IDLE, WRITEBACK, FETCH, UPDATE.
//   - IDLE: BUSYWAIT = (READ|WRITE) && !hit, combinational.
//     Read hit: READDATA = byte[offset] combinationally, zero stall.
//     Write hit: byte written at posedge, dirty=1, zero stall.
//     Miss with clean or invalid victim goes to FETCH. Miss with valid dirty victim goes to WRITEBACK.
//   - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={tag[idx],idx}, MEM_WRITEDATA=data[idx].
//     At the first posedge with MEM_BUSYWAIT=0, go to FETCH.
//   - FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag,idx}. At the first posedge with MEM_BUSYWAIT=0,
//     go to UPDATE.
//   - UPDATE: one cycle. At posedge, data[idx]=MEM_READDATA, tag updated, valid=1, dirty=0.
//     Then go to IDLE, where the access now hits and completes. Clean-miss stall = mem latency + 2 cycles.
//   - BUSYWAIT=1 in every non-IDLE state. MEM_READ and MEM_WRITE are never high together.
//     Both are 0 in IDLE and UPDATE.
//   - READ and WRITE both high: treated as WRITE, READDATA don't-care.
//   - Outputs are decoded from registered state (Moore) except the IDLE hit path.
//   - Reset: state=IDLE, all valid=0, dirty=0. MEM_READ=MEM_WRITE=0 and BUSYWAIT=0 while no request.
//     RESET mid-WRITEBACK/FETCH aborts the transfer next cycle; dirty data is discarded.
//   - Index/tag arithmetic is pure bit slicing; no wrap-around cases exist.
// CONFIGURATION
//   DCACHE_STATS_EN defined: adds out ports HIT_COUNT[15:0] and MISS_COUNT[15:0].
//     Counts are taken once per access, at the IDLE posedge where the access hits or first misses.
//     The replay hit after UPDATE is not counted. Counters saturate at 16'hFFFF and are cleared by RESET.
//   DCACHE_STATS_EN undefined: those ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//   1 Reset, READ 8'h25 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h09.
//     Mem returns 32'hDDCCBBAA -> READDATA=8'hBB, BUSYWAIT=0.
//   2 Then WRITE 8'h26, data 8'h5A -> BUSYWAIT stays 0, no MEM_* activity.
//     READ 8'h26 -> 8'h5A same cycle.
//   3 Then READ 8'h45 -> MEM_WRITE=1, MEM_ADDRESS=6'h09, MEM_WRITEDATA=32'hDD5ABBAA.
//     Then MEM_READ=1 at 6'h11, never both high.
//   4 RESET pulsed during FETCH -> next cycle MEM_READ=0. READ 8'h25 misses again.
//   5 READ=WRITE=0 for 20 cycles -> BUSYWAIT=0, MEM_READ=MEM_WRITE=0 throughout.
//   6 DCACHE_STATS_EN defined: run scenarios 1-3 -> HIT_COUNT=2, MISS_COUNT=2.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller between CPU and block memory.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller #(
    parameter int ADDR_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic                        WRITE,
    input  logic [ADDR_W-1:0]           ADDRESS,
    input  logic [7:0]                  WRITEDATA,
    output logic [7:0]                  READDATA,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic                        MEM_WRITE,
    output logic [ADDR_W-OFFSET_W-1:0]  MEM_ADDRESS,
    output logic [8*(2**OFFSET_W)-1:0]  MEM_WRITEDATA,
    input  logic [8*(2**OFFSET_W)-1:0]  MEM_READDATA,
`ifdef DCACHE_STATS_EN
    output logic [15:0]                 HIT_COUNT,
    output logic [15:0]                 MISS_COUNT,
`endif
    input  logic                        MEM_BUSYWAIT
);

    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES   = 2 ** INDEX_W;
    localparam int BLOCK_W = 8 * (2 ** OFFSET_W);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_W-1:0]       tags   [LINES];
    logic [BLOCK_W-1:0]     blocks [LINES];

    logic [TAG_W-1:0]       tag;
    logic [INDEX_W-1:0]     idx;
    logic [OFFSET_W-1:0]    offset;
    logic [OFFSET_W+2:0]    bit_sel;
    logic                   request;
    logic                   hit;

    assign tag     = ADDRESS[ADDR_W-1 -: TAG_W];
    assign idx     = ADDRESS[OFFSET_W +: INDEX_W];
    assign offset  = ADDRESS[OFFSET_W-1:0];
    assign bit_sel = {offset, 3'b000};
    assign request = READ | WRITE;
    assign hit     = valid[idx] && (tags[idx] == tag);

    // The hit path is the only combinational route from CPU request to CPU-facing outputs.
    assign READDATA      = blocks[idx][bit_sel +: 8];
    assign BUSYWAIT      = (state != IDLE) || (request && !hit);
    assign MEM_ADDRESS   = (state == WRITEBACK) ? {tags[idx], idx} : {tag, idx};
    assign MEM_WRITEDATA = blocks[idx];

    // Miss sequencing; MEM_READ/MEM_WRITE are registered alongside the state they belong to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WRITEBACK;
                            MEM_WRITE <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            MEM_READ <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state     <= FETCH;
                        MEM_WRITE <= 1'b0;
                        MEM_READ  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= UPDATE;
                        MEM_READ <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage: store hits write one byte; UPDATE installs the fetched block clean.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == UPDATE) begin
            blocks[idx] <= MEM_READDATA;
            tags[idx]   <= tag;
            valid[idx]  <= 1'b1;
            dirty[idx]  <= 1'b0;
        end else if (state == IDLE && WRITE && hit) begin
            blocks[idx][bit_sel +: 8] <= WRITEDATA;
            dirty[idx]                <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic replay;

    // The IDLE cycle right after UPDATE is the replay of an already-counted miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            replay     <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            replay <= (state == UPDATE);
            if (state == IDLE && request && !replay) begin
                if (hit && HIT_COUNT != 16'hFFFF) begin
                    HIT_COUNT <= HIT_COUNT + 16'd1;
                end else if (!hit && MISS_COUNT != 16'hFFFF) begin
                    MISS_COUNT <= MISS_COUNT + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural block memory of fixed latency.
// Stats checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT),
`endif
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Block memory: busy for MEM_LAT cycles from the start of each new request, then accepts it.
    localparam int MEM_LAT = 2;
    logic [31:0] tb_mem [64];
    logic        mem_init;
    logic [1:0]  cur_req;
    logic [1:0]  prev_req = 2'b00;
    int          lat_cnt  = 0;
    int          cnt_eff;

    assign cur_req      = {MEM_READ, MEM_WRITE};
    assign MEM_READDATA = tb_mem[MEM_ADDRESS];

    always_comb begin
        cnt_eff      = (cur_req == prev_req) ? lat_cnt : 0;
        MEM_BUSYWAIT = (cur_req != 2'b00) && (cnt_eff < MEM_LAT);
    end

    always @(posedge CLK) begin
        prev_req <= cur_req;
        lat_cnt  <= cnt_eff + 1;
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                tb_mem[i] <= {4{i[7:0]}};
            end
            tb_mem[6'h09] <= 32'hDDCCBBAA;
            tb_mem[6'h11] <= 32'h44332211;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            tb_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp_rdata;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitNotBusy(input int budget, output logic done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    logic done;
    logic saw_read;
    logic saw_both;
    logic [5:0] read_addr;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 8'h11, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h44, 8'h77, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 8'h77, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h47, 8'h00, 1'b1, 8'h44, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h47, 8'hE1, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h47, 8'h00, 1'b1, 8'hE1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h45, 8'h3C, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h45, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 8'h46, 8'h00, 1'b1, 8'h33, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        mem_init = 1'b1;
        RESET    = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        mem_init = 1'b0;
        checkOutput("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        checkOutput("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        checkOutput("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        RESET = 1'b0;
        step();

        // Cold read miss, clean fetch of block 0x09.
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        #1;
        checkOutput("s1_busy_on_miss", {31'd0, BUSYWAIT}, 32'd1);
        step();
        checkOutput("s1_mem_read", {31'd0, MEM_READ}, 32'd1);
        checkOutput("s1_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        checkOutput("s1_mem_address", {26'd0, MEM_ADDRESS}, 32'h09);
        waitNotBusy(30, done);
        checkOutput("s1_completed", {31'd0, done}, 32'd1);
        checkOutput("s1_readdata", {24'd0, READDATA}, 32'hBB);
        step();

        // Store hit then load hit on the same line.
        applyStimulus(1'b0, 1'b1, 8'h26, 8'h5A);
        #1;
        checkOutput("s2_write_busy", {31'd0, BUSYWAIT}, 32'd0);
        checkOutput("s2_write_mem_req", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 8'h26, 8'h00);
        #1;
        checkOutput("s2_read_busy", {31'd0, BUSYWAIT}, 32'd0);
        checkOutput("s2_readdata", {24'd0, READDATA}, 32'h5A);
        step();

        // Conflict miss on a dirty line: write-back then fetch of block 0x11.
        applyStimulus(1'b1, 1'b0, 8'h45, 8'h00);
        #1;
        checkOutput("s3_busy_on_miss", {31'd0, BUSYWAIT}, 32'd1);
        step();
        checkOutput("s3_mem_write", {31'd0, MEM_WRITE}, 32'd1);
        checkOutput("s3_mem_read_low", {31'd0, MEM_READ}, 32'd0);
        checkOutput("s3_wb_address", {26'd0, MEM_ADDRESS}, 32'h09);
        checkOutput("s3_wb_data", MEM_WRITEDATA, 32'hDD5ABBAA);
        saw_read  = 1'b0;
        saw_both  = 1'b0;
        read_addr = '0;
        done      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MEM_READ && MEM_WRITE) saw_both = 1'b1;
            if (MEM_READ && !saw_read) begin
                saw_read  = 1'b1;
                read_addr = MEM_ADDRESS;
            end
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("s3_completed", {31'd0, done}, 32'd1);
        checkOutput("s3_saw_fetch", {31'd0, saw_read}, 32'd1);
        checkOutput("s3_fetch_address", {26'd0, read_addr}, 32'h11);
        checkOutput("s3_never_both", {31'd0, saw_both}, 32'd0);
        checkOutput("s3_readdata", {24'd0, READDATA}, 32'h22);
        checkOutput("s3_mem_written_back", tb_mem[6'h09], 32'hDD5ABBAA);
        step();

`ifdef DCACHE_STATS_EN
        checkOutput("stats_hit_count", {16'd0, HIT_COUNT}, 32'd2);
        checkOutput("stats_miss_count", {16'd0, MISS_COUNT}, 32'd2);
`endif

        // Single-cycle hit traffic on the freshly filled line.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, BUSYWAIT}, {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("vec%0d_mem_req", i), {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d_readdata", i), {24'd0, READDATA},
                            {24'd0, vecs[i].exp_rdata});
            end
            step();
        end

        // Reset during the fetch aborts the transfer and invalidates the cache.
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        #1;
        checkOutput("s4_busy_on_miss", {31'd0, BUSYWAIT}, 32'd1);
        step();
        checkOutput("s4_dirty_writeback", {31'd0, MEM_WRITE}, 32'd1);
        saw_read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MEM_READ) begin
                saw_read = 1'b1;
                break;
            end
        end
        checkOutput("s4_reached_fetch", {31'd0, saw_read}, 32'd1);
        RESET = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        checkOutput("s4_abort_mem_read", {31'd0, MEM_READ}, 32'd0);
        checkOutput("s4_abort_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        RESET = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        #1;
        checkOutput("s4_miss_again", {31'd0, BUSYWAIT}, 32'd1);
        step();
        checkOutput("s4_clean_fetch", {30'd0, MEM_READ, MEM_WRITE}, 32'b10);
        waitNotBusy(30, done);
        checkOutput("s4_completed", {31'd0, done}, 32'd1);
        checkOutput("s4_readdata", {24'd0, READDATA}, 32'hBB);
        step();

        // Long idle stretch: no stall, no memory traffic.
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput($sformatf("s5_idle_cycle%0d", i), {29'd0, BUSYWAIT, MEM_READ, MEM_WRITE},
                        32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
